uart_tx_fifo: RTL and testbench

//  Buffered 8N1 UART transmitter driving the board uart_tx pin.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/uart_tx_fifo.sv | 139 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default baud divider and the TX/RX FSM state types.
package uart_pkg;

  // 27 MHz / 115200 baud
  localparam int unsigned DefaultDelayFrames = 234;

  // 8N1 frame: one start bit, eight data bits, one stop bit
  localparam int unsigned FrameDataBits = 8;
  localparam int unsigned FrameBits     = 10;

  // Baud counter width; covers dividers up to 8191
  localparam int unsigned BaudCntW = 13;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   push_i, din_i  write request and data (ignored when full)
//   pop_i          read request (ignored when empty)
//   dout_o         combinational head of the queue
//   full_o/empty_o occupancy flags
//   count_o        occupancy, 0..Depth
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [Width-1:0]         din_i,
  output logic [Width-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [AddrW:0]     wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]     rd_ptr_q, rd_ptr_d;
  logic [Width-1:0]   mem_q [Depth];
  logic               push_en;
  logic               pop_en;

  // Same index with differing wrap bit means the writer is a full lap ahead.
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign dout_o  = mem_q[rd_ptr_q[AddrW-1:0]];

  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AddrW{1'b0}}, push_en};
    rd_ptr_d = rd_ptr_q + {{AddrW{1'b0}}, pop_en};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter. Bytes pushed over valid/ready are queued in a sync_fifo and
// serialised LSB first at DelayFrames clk cycles per bit. Back-to-back frames have no idle gap.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset (aborts any frame, flushes the queue)
//   in_data_i      byte to transmit
//   in_valid_i     in_data_i valid
//   in_ready_o     FIFO not full; push when in_valid_i && in_ready_o
//   uart_tx_o      serial line, idles high, driven from a flop
//   tx_busy_o      frame in progress or bytes queued
//   fifo_count_o   queue occupancy, 0..FifoDepth
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DelayFrames = DefaultDelayFrames,
  parameter int unsigned FifoDepth   = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [7:0]                   in_data_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic                         uart_tx_o,
  output logic                         tx_busy_o,
  output logic [$clog2(FifoDepth):0]   fifo_count_o
);

  tx_state_e             state_q, state_d;
  logic [BaudCntW-1:0]   baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic                  tx_q, tx_d;

  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [7:0]            fifo_dout;
  logic                  baud_last;

  sync_fifo #(
    .Width (8),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (in_valid_i),
    .pop_i   (pop),
    .din_i   (in_data_i),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_o)
  );

  assign in_ready_o = !fifo_full;
  assign tx_busy_o  = (state_q != StIdle) || !fifo_empty;
  assign uart_tx_o  = tx_q;
  assign baud_last  = (baud_q == BaudCntW'(DelayFrames - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          baud_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + BaudCntW'(1);
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'(FrameDataBits - 1)) begin
            state_d = StStop;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + BaudCntW'(1);
        end
      end
      StStop: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next frame when more bytes are waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + BaudCntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Line level is a function of the next state so it changes on the same edge as the FSM.
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo with DelayFrames=4, FifoDepth=4. A queue-based reference model predicts
// the line waveform, occupancy, ready and busy every cycle; directed cases cover the listed
// scenarios and a randomized phase stresses push/pop overlap and pointer wrap.
module tb_uart_tx_fifo;

  localparam int unsigned Df    = 4;
  localparam int unsigned Depth = 4;
  localparam int unsigned CntW  = $clog2(Depth) + 1;
  localparam int unsigned FrameCycles = 10 * Df;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [7:0]      in_data = 8'h00;
  logic            in_valid = 1'b0;
  logic            in_ready_o;
  logic            uart_tx_o;
  logic            tx_busy_o;
  logic [CntW-1:0] fifo_count_o;

  uart_tx_fifo #(
    .DelayFrames (Df),
    .FifoDepth   (Depth)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_data_i    (in_data),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready_o),
    .uart_tx_o    (uart_tx_o),
    .tx_busy_o    (tx_busy_o),
    .fifo_count_o (fifo_count_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: bytes waiting, and the frame currently on the line.
  logic [7:0] q[$];
  bit         active = 1'b0;
  int         pos = 0;
  logic [7:0] fbyte = 8'h00;

  function automatic logic exp_line();
    int b;
    if (!active) return 1'b1;
    b = pos / Df;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return fbyte[b-1];
  endfunction

  initial begin
    bit do_pop, do_push;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        q.delete();
        active = 1'b0;
        pos = 0;
      end else begin
        check_eq("uart_tx", {31'd0, uart_tx_o}, {31'd0, exp_line()});
        check_eq("fifo_count", {29'd0, fifo_count_o}, q.size());
        check_eq("in_ready", {31'd0, in_ready_o}, {31'd0, q.size() < Depth});
        check_eq("tx_busy", {31'd0, tx_busy_o}, {31'd0, active || q.size() != 0});
        // Predict the next edge: a frame starts when bytes wait and the line is free or ending.
        do_pop  = (q.size() != 0) && (!active || pos == FrameCycles - 1);
        do_push = in_valid && (q.size() < Depth);
        if (do_pop) begin
          fbyte = q.pop_front();
          active = 1'b1;
          pos = 0;
        end else if (active) begin
          pos++;
          if (pos == FrameCycles) active = 1'b0;
        end
        if (do_push) q.push_back(in_data);
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    int t;
    in_data = b;
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready_o && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check_eq("push_wait", t, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (tx_busy_o && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check_eq("idle_wait", t, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_tx"}, {31'd0, uart_tx_o}, 32'd1);
    check_eq({tag, "_count"}, {29'd0, fifo_count_o}, 32'd0);
    check_eq({tag, "_ready"}, {31'd0, in_ready_o}, 32'd1);
    check_eq({tag, "_busy"}, {31'd0, tx_busy_o}, 32'd0);
  endtask

  initial begin
    logic [9:0] bits;
    // Reset
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // 0x55 frame: sample the middle of each bit independently of the model
    push_byte(8'h55);
    @(posedge clk);
    bits = '0;
    for (int i = 0; i < int'(FrameCycles); i++) begin
      @(negedge clk);
      if (i % Df == 2) bits[i/Df] = uart_tx_o;
    end
    check_eq("frame55_bits", {22'd0, bits}, 32'h2AA);
    @(negedge clk);
    check_eq("frame55_busy_end", {31'd0, tx_busy_o}, 32'd0);
    check_eq("frame55_line_end", {31'd0, uart_tx_o}, 32'd1);
    @(posedge clk);
    #1;

    // Two consecutive pushes, back-to-back frames
    push_byte(8'h41);
    push_byte(8'h0A);
    wait_idle();

    // Six bytes with valid held; FIFO fills and in_ready drops
    for (int i = 0; i < 6; i++) push_byte(8'hC0 + 8'(i));
    wait_idle();

    // Reset in the middle of the data bits of 0xA3 with two bytes queued
    push_byte(8'hA3);
    push_byte(8'h11);
    push_byte(8'h22);
    repeat (5 * Df) @(posedge clk);
    #3;
    check_eq("pre_reset_count", {29'd0, fifo_count_o}, 32'd2);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check_eq("post_reset_line", {31'd0, uart_tx_o}, 32'd1);

    // Randomized traffic: overlapping push/pop at every occupancy, pointer wrap
    for (int c = 0; c < 1500; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
